// File: rtl/fifo_lvl_pkg.sv
// Shared helpers for the fifo_lvl block: width computation used by ports and pointers.
package fifo_lvl_pkg;

    // Bits needed to encode values 0..value-1; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: DEPTH x DATAW, synchronous write, asynchronous read, no reset.
module fifo_ram #(
    parameter int DATAW = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DATAW-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [DATAW-1:0] rdata
);

    logic [DATAW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_lvl.sv
// Show-ahead synchronous FIFO with occupancy count, level flags and sticky
// overflow/underflow flags. Flags derive from the registered count only.
module fifo_lvl
    import fifo_lvl_pkg::*;
#(
    parameter int DATAW  = 8,
    parameter int DEPTH  = 4,
    parameter int AF_THR = DEPTH - 1,
    parameter int AE_THR = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic [DATAW-1:0]             i_wr_data,
    input  logic                         i_wr_en,
    output logic                         o_wr_full,
    output logic                         o_wr_afull,
    output logic [DATAW-1:0]             o_rd_data,
    input  logic                         i_rd_en,
    output logic                         o_rd_empty,
    output logic                         o_rd_aempty,
    output logic [clog2(DEPTH+1)-1:0]    o_count,
    output logic                         o_ovf,
    output logic                         o_udf,
    input  logic                         i_err_clr
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int PW = clog2(DEPTH);

    if (DEPTH < 2 || DATAW < 1 || AE_THR >= AF_THR || AF_THR > DEPTH || AE_THR < 0) begin : g_bad_params
        $error("fifo_lvl: illegal parameters (need DEPTH>=2, DATAW>=1, 0<=AE_THR<AF_THR<=DEPTH)");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          udf;
    logic          full;
    logic          empty;
    logic          rd_ok;
    logic          wr_ok;
    logic          wr_rej;
    logic          rd_rej;

    // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign rd_ok  = i_rd_en & ~empty;
    assign wr_ok  = i_wr_en & (~full | rd_ok);
    assign wr_rej = i_wr_en & ~wr_ok;
    assign rd_rej = i_rd_en & empty;

    fifo_ram #(
        .DATAW (DATAW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok & ~i_flush),
        .waddr (wr_ptr),
        .wdata (i_wr_data),
        .raddr (rd_ptr),
        .rdata (o_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
                if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
                if (wr_ok && !rd_ok) begin
                    count <= count + 1'b1;
                end else if (rd_ok && !wr_ok) begin
                    count <= count - 1'b1;
                end
            end
            // A new error event wins over a coincident clear.
            if (wr_rej && !i_flush) begin
                ovf <= 1'b1;
            end else if (i_err_clr) begin
                ovf <= 1'b0;
            end
            if (rd_rej) begin
                udf <= 1'b1;
            end else if (i_err_clr) begin
                udf <= 1'b0;
            end
        end
    end

    assign o_count     = count;
    assign o_wr_full   = full;
    assign o_wr_afull  = (count >= CW'(AF_THR));
    assign o_rd_empty  = empty;
    assign o_rd_aempty = (count <= CW'(AE_THR));
    assign o_ovf       = ovf;
    assign o_udf       = udf;

endmodule

// File: tb/tb_fifo_lvl.sv
// Self-checking bench for fifo_lvl: DEPTH=4 and DEPTH=5 instances share stimulus,
// a queue model tracks contents and flags.
module tb_fifo_lvl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;

    logic       full4, afull4, empty4, aempty4, ovf4, udf4;
    logic [7:0] dout4;
    logic [2:0] count4;
    logic       full5, afull5, empty5, aempty5, ovf5, udf5;
    logic [7:0] dout5;
    logic [2:0] count5;

    logic [7:0] exp_q[$];
    int  sel = 0;
    logic m_ovf = 1'b0;
    logic m_udf = 1'b0;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    fifo_lvl #(.DATAW(8), .DEPTH(4), .AF_THR(3), .AE_THR(1)) dut4 (
        .clk(clk), .rst(rst), .i_flush(flush), .i_wr_data(wr_data), .i_wr_en(wr_en),
        .o_wr_full(full4), .o_wr_afull(afull4), .o_rd_data(dout4), .i_rd_en(rd_en),
        .o_rd_empty(empty4), .o_rd_aempty(aempty4), .o_count(count4),
        .o_ovf(ovf4), .o_udf(udf4), .i_err_clr(err_clr)
    );

    fifo_lvl #(.DATAW(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .i_flush(flush), .i_wr_data(wr_data), .i_wr_en(wr_en),
        .o_wr_full(full5), .o_wr_afull(afull5), .o_rd_data(dout5), .i_rd_en(rd_en),
        .o_rd_empty(empty5), .o_rd_aempty(aempty5), .o_count(count5),
        .o_ovf(ovf5), .o_udf(udf5), .i_err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int depth();
        return (sel == 1) ? 5 : 4;
    endfunction

    task automatic check_status();
        int n;
        n = exp_q.size();
        check("count",  (sel == 1) ? 32'(count5)  : 32'(count4),  32'(n));
        check("empty",  (sel == 1) ? 32'(empty5)  : 32'(empty4),  32'(n == 0));
        check("full",   (sel == 1) ? 32'(full5)   : 32'(full4),   32'(n == depth()));
        check("afull",  (sel == 1) ? 32'(afull5)  : 32'(afull4),  32'(n >= depth() - 1));
        check("aempty", (sel == 1) ? 32'(aempty5) : 32'(aempty4), 32'(n <= 1));
        check("ovf",    (sel == 1) ? 32'(ovf5)    : 32'(ovf4),    32'(m_ovf));
        check("udf",    (sel == 1) ? 32'(udf5)    : 32'(udf4),    32'(m_udf));
        if (n > 0) begin
            check("head", (sel == 1) ? 32'(dout5) : 32'(dout4), 32'(exp_q[0]));
        end
    endtask

    // One clock of stimulus; the model is updated from the same inputs and compared after the edge.
    task automatic step(input logic wr, input logic [7:0] wd, input logic rd,
                        input logic fl, input logic clr);
        logic rd_ok, wr_ok;
        wr_en = wr; wr_data = wd; rd_en = rd; flush = fl; err_clr = clr;
        rd_ok = rd && (exp_q.size() > 0);
        wr_ok = wr && ((exp_q.size() < depth()) || rd_ok);
        if (wr && !wr_ok && !fl) m_ovf = 1'b1;
        else if (clr)            m_ovf = 1'b0;
        if (rd && exp_q.size() == 0) m_udf = 1'b1;
        else if (clr)                m_udf = 1'b0;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (rd_ok) void'(exp_q.pop_front());
            if (wr_ok) exp_q.push_back(wd);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        check_status();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b1; rd_en = 1'b1; flush = 1'b1; err_clr = 1'b0; wr_data = 8'hAA;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_status();
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(logic'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
                 logic'($urandom_range(0, 99) < 45), logic'($urandom_range(0, 99) < 3),
                 logic'($urandom_range(0, 99) < 10));
        end
    endtask

    initial begin
        sel = 0;
        do_reset();
        check("reset_afull", 32'(afull4), 32'd0);

        // Fill and drain
        for (int v = 15; v <= 18; v++) step(1'b1, 8'(v), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);

        // Overflow, then clear
        for (int v = 15; v <= 18; v++) step(1'b1, 8'(v), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd99, 1'b0, 1'b0, 1'b0);
        check("ovf_set", 32'(ovf4), 32'd1);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);

        // Read+write while full, then drain 16,17,18,55
        step(1'b1, 8'd55, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);

        // Read+write while empty: write only, underflow flagged
        step(1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
        check("rw_empty_head", 32'(dout4), 32'd7);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        // Clear coinciding with a new underflow keeps the flag set
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);

        // Flush with 3 entries overrides a simultaneous write
        for (int v = 1; v <= 3; v++) step(1'b1, 8'(v), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd42, 1'b0, 1'b1, 1'b0);
        // Flush while full with a write must not flag overflow
        for (int v = 60; v <= 63; v++) step(1'b1, 8'(v), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd64, 1'b0, 1'b1, 1'b0);

        // Reset mid-operation with 2 entries
        step(1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'd200, 1'b0, 1'b0, 1'b0);
        check("post_rst_head", 32'(dout4), 32'd200);

        random_run(300);

        // DEPTH=5 wrap
        sel = 1;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int k = 1; k <= 3; k++) step(1'b1, 8'(r * 3 + k), 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        end
        check("wrap_count", 32'(count5), 32'd0);
        check("wrap_ovf", 32'(ovf5), 32'd0);
        check("wrap_udf", 32'(udf5), 32'd0);
        for (int v = 20; v <= 25; v++) step(1'b1, 8'(v), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd26, 1'b1, 1'b0, 1'b0);
        random_run(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
